tank_plant_model: RTL and testbench

//   Cycle-based model of the water tank plus its H/M/L level sensors: the responder to the

---
 rtl/tank_plant_model.sv | 152 +++++++++++++++
 tb/tb_tank_plant_model.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_plant_model.sv
// Cycle-based water tank plant: integrates inlet/drip/spray valve commands into a saturating
// level once per prescaled tick and reports H/M/L sensor bits, with sensor fault injection.
module tank_plant_model #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned CAP        = 200,
    parameter int unsigned L_TH       = 50,
    parameter int unsigned M_TH       = 100,
    parameter int unsigned H_TH       = 150,
    parameter int unsigned FILL_RATE  = 3,
    parameter int unsigned DRIP_RATE  = 1,
    parameter int unsigned SPRAY_RATE = 2,
    parameter int unsigned TICK_DIV   = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Ve,
    input  logic               Vs,
    input  logic               Bs,
    input  logic               load_en,
    input  logic [LEVEL_W-1:0] load_level,
    input  logic [1:0]         fault_sel,
    input  logic               clr_flags,
    output logic               H,
    output logic               M,
    output logic               L,
    output logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               overflow,
    output logic               dry_run
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W = LEVEL_W + 2;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0]       CAP_L    = LEVEL_W'(CAP);
    localparam logic [LEVEL_W-1:0]       L_TH_L   = LEVEL_W'(L_TH);
    localparam logic [LEVEL_W-1:0]       M_TH_L   = LEVEL_W'(M_TH);
    localparam logic [LEVEL_W-1:0]       H_TH_L   = LEVEL_W'(H_TH);
    localparam logic signed [SUM_W-1:0]  CAP_S    = SUM_W'(CAP);
    localparam logic signed [SUM_W-1:0]  FILL_S   = SUM_W'(FILL_RATE);
    localparam logic signed [SUM_W-1:0]  DRIP_S   = SUM_W'(DRIP_RATE);
    localparam logic signed [SUM_W-1:0]  SPRAY_S  = SUM_W'(SPRAY_RATE);

    typedef enum logic [1:0] {
        StNorm = 2'b00,
        StL0   = 2'b01,
        StM0   = 2'b10,
        StFrz  = 2'b11
    } state_t;

    logic [CNT_W-1:0]         cnt_q;
    logic [LEVEL_W-1:0]       level_q;
    logic [LEVEL_W-1:0]       level_upd;
    logic [LEVEL_W-1:0]       load_sat;
    logic                     tick_q;
    logic                     overflow_q;
    logic                     dry_run_q;
    logic signed [SUM_W-1:0]  fill_s;
    logic signed [SUM_W-1:0]  drip_s;
    logic signed [SUM_W-1:0]  spray_s;
    logic signed [SUM_W-1:0]  sum;
    logic                     set_ov;
    logic                     set_dr;
    logic [2:0]               raw;
    logic [2:0]               hml_q;
    logic [2:0]               frz_q;
    state_t                   state_q;
    state_t                   state_d;

    always_comb begin
        fill_s  = '0;
        drip_s  = '0;
        spray_s = '0;
        if (Ve) fill_s = FILL_S;
        if (Vs) drip_s = DRIP_S;
        if (Bs) spray_s = SPRAY_S;
        sum = $signed({2'b00, level_q}) + fill_s - drip_s - spray_s;
        // Saturate into [0, CAP]; the two extra sum bits keep the sign unambiguous.
        if (sum[SUM_W-1]) begin
            level_upd = '0;
        end else if (sum > CAP_S) begin
            level_upd = CAP_L;
        end else begin
            level_upd = sum[LEVEL_W-1:0];
        end
        load_sat = (load_level > CAP_L) ? CAP_L : load_level;
        set_ov   = tick_q && !load_en && Ve && (level_q == CAP_L);
        set_dr   = tick_q && !load_en && (Vs || Bs) && (level_q == '0);
        raw      = {level_q >= H_TH_L, level_q >= M_TH_L, level_q >= L_TH_L};
        state_d  = state_t'(fault_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            level_q    <= '0;
            tick_q     <= 1'b0;
            overflow_q <= 1'b0;
            dry_run_q  <= 1'b0;
        end else begin
            if (load_en) begin
                level_q <= load_sat;
                cnt_q   <= '0;
                tick_q  <= 1'b0;
            end else begin
                if (tick_q) level_q <= level_upd;
                tick_q <= (cnt_q == CNT_LAST);
                cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            if (set_ov) begin
                overflow_q <= 1'b1;
            end else if (clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (set_dr) begin
                dry_run_q <= 1'b1;
            end else if (clr_flags) begin
                dry_run_q <= 1'b0;
            end
        end
    end

    // Sensor outputs follow the state being entered so a fault_sel change shows next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StNorm;
            hml_q   <= '0;
            frz_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_d)
                StNorm: hml_q <= raw;
                StL0:   hml_q <= raw & 3'b110;
                StM0:   hml_q <= raw & 3'b101;
                StFrz: begin
                    if (state_q != StFrz) begin
                        frz_q <= hml_q;
                    end else begin
                        hml_q <= frz_q;
                    end
                end
            endcase
        end
    end

    assign {H, M, L} = hml_q;
    assign level     = level_q;
    assign tick      = tick_q;
    assign overflow  = overflow_q;
    assign dry_run   = dry_run_q;

endmodule

// File: tb/tb_tank_plant_model.sv
// Scoreboard bench for tank_plant_model: directed scenarios plus random valve/load/fault traffic,
// every cycle checked against a behavioural tank model.
module tb_tank_plant_model;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Ve = 1'b0, Vs = 1'b0, Bs = 1'b0;
    logic       load_en = 1'b0, clr_flags = 1'b0;
    logic [7:0] load_level = '0;
    logic [1:0] fault_sel = '0;
    logic       H, M, L, tick, overflow, dry_run;
    logic [7:0] level;

    tank_plant_model #(
        .LEVEL_W   (8),
        .CAP       (200),
        .L_TH      (50),
        .M_TH      (100),
        .H_TH      (150),
        .FILL_RATE (3),
        .DRIP_RATE (1),
        .SPRAY_RATE(2),
        .TICK_DIV  (TD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ve        (Ve),
        .Vs        (Vs),
        .Bs        (Bs),
        .load_en   (load_en),
        .load_level(load_level),
        .fault_sel (fault_sel),
        .clr_flags (clr_flags),
        .H         (H),
        .M         (M),
        .L         (L),
        .level     (level),
        .tick      (tick),
        .overflow  (overflow),
        .dry_run   (dry_run)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [13:0] expq[$];

    // Reference model state
    int       m_level = 0;
    int       m_cnt = 0;
    bit       m_tick = 0, m_ov = 0, m_dr = 0;
    bit [2:0] m_hml = 0, m_frz = 0;
    bit [1:0] m_fs = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        int       lvl;
        int       t;
        bit [2:0] raw;
        bit       set_ov, set_dr;
        if (!rst_n) begin
            m_level = 0; m_cnt = 0; m_tick = 0; m_ov = 0; m_dr = 0;
            m_hml = 0; m_frz = 0; m_fs = 0;
        end else begin
            lvl    = m_level;
            raw    = {lvl >= 150, lvl >= 100, lvl >= 50};
            set_ov = 0;
            set_dr = 0;
            case (fault_sel)
                2'd0: m_hml = raw;
                2'd1: m_hml = {raw[2], raw[1], 1'b0};
                2'd2: m_hml = {raw[2], 1'b0, raw[0]};
                default: begin
                    if (m_fs == 2'd3) m_hml = m_frz;
                    else m_frz = m_hml;
                end
            endcase
            m_fs = fault_sel;
            if (load_en) begin
                m_level = (int'(load_level) > 200) ? 200 : int'(load_level);
                m_cnt   = 0;
                m_tick  = 0;
            end else begin
                if (m_tick) begin
                    set_ov = Ve && (lvl == 200);
                    set_dr = (Vs || Bs) && (lvl == 0);
                    t = lvl + 3 * int'(Ve) - int'(Vs) - 2 * int'(Bs);
                    m_level = (t < 0) ? 0 : ((t > 200) ? 200 : t);
                end
                m_tick = (m_cnt == TD - 1);
                m_cnt  = (m_cnt + 1) % TD;
            end
            m_ov = set_ov ? 1'b1 : (clr_flags ? 1'b0 : m_ov);
            m_dr = set_dr ? 1'b1 : (clr_flags ? 1'b0 : m_dr);
        end
    endtask

    task automatic cyc(input int n);
        logic [7:0] lv;
        repeat (n) begin
            model_step();
            lv = m_level[7:0];
            expq.push_back({lv, m_tick, m_hml, m_ov, m_dr});
            @(negedge clk);
        end
    endtask

    task automatic load(input int v);
        load_level = 8'(v);
        load_en    = 1'b1;
        cyc(1);
        load_en    = 1'b0;
    endtask

    // Monitor: pop one expectation per rising edge and compare all outputs.
    initial begin
        logic [13:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                g = {level, tick, H, M, L, overflow, dry_run};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL scoreboard: got lvl=%0d tick=%b hml=%b ov=%b dr=%b expected lvl=%0d tick=%b hml=%b ov=%b dr=%b at %0t",
                             g[13:6], g[5], g[4:2], g[1], g[0], e[13:6], e[5], e[4:2], e[1], e[0],
                             $time);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        cyc(2);
        chk("reset_outputs", int'({level, tick, H, M, L, overflow, dry_run}), 0);
        rst_n = 1'b1;

        // Fill from empty: L after 17 ticks, M after 34, H at 150
        Ve = 1'b1;
        cyc(70);
        chk("fill_level_51", int'(level), 51);
        chk("fill_L_set", int'({H, M, L}), 3'b001);
        cyc(68);
        chk("fill_level_102", int'(level), 102);
        chk("fill_M_set", int'({H, M, L}), 3'b011);
        cyc(64);
        chk("fill_level_150", int'(level), 150);
        chk("fill_H_set", int'({H, M, L}), 3'b111);

        // Overflow at capacity, then clear
        load(200);
        cyc(6);
        chk("full_level", int'(level), 200);
        chk("overflow_set", int'(overflow), 1);
        Ve = 1'b0;
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        chk("overflow_clr", int'(overflow), 0);

        // Drain below zero saturates, then dry_run
        Vs = 1'b1; Bs = 1'b1;
        load(2);
        cyc(5);
        chk("drain_sat0", int'(level), 0);
        chk("dry_run_not_yet", int'(dry_run), 0);
        cyc(4);
        chk("dry_run_set", int'(dry_run), 1);
        Vs = 1'b0; Bs = 1'b0;
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;

        // Stuck-at faults
        fault_sel = 2'b01;
        load(120);
        cyc(1);
        chk("fault_L0", int'({H, M, L}), 3'b010);
        fault_sel = 2'b10;
        load(160);
        cyc(1);
        chk("fault_M0", int'({H, M, L}), 3'b101);

        // Frozen sensors while level keeps integrating
        fault_sel = 2'b00;
        load(60);
        cyc(2);
        chk("pre_freeze", int'({H, M, L}), 3'b001);
        fault_sel = 2'b11;
        Ve = 1'b1;
        cyc(160);
        chk("frozen_level", int'(level), 180);
        chk("frozen_hml", int'({H, M, L}), 3'b001);
        fault_sel = 2'b00;
        Ve = 1'b0;
        cyc(1);
        chk("unfreeze_hml", int'({H, M, L}), 3'b111);

        // load_en coincident with a tick cycle
        load(10);
        Ve = 1'b1;
        cyc(4);
        chk("tick_before_load", int'(tick), 1);
        load(77);
        chk("load_on_tick_level", int'(level), 77);
        chk("load_on_tick_tick", int'(tick), 0);
        cyc(4);
        chk("restart_tick", int'(tick), 1);
        cyc(1);
        chk("restart_update", int'(level), 80);

        // Asynchronous reset mid-fill
        cyc(7);
        rst_n = 1'b0;
        #1;
        chk("async_reset", int'({level, tick, H, M, L, overflow, dry_run}), 0);
        cyc(2);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            Ve         = ($urandom_range(0, 9) < 6);
            Vs         = $urandom_range(0, 1) == 1;
            Bs         = ($urandom_range(0, 3) == 0);
            load_en    = ($urandom_range(0, 39) == 0);
            load_level = 8'($urandom_range(0, 255));
            clr_flags  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) fault_sel = 2'($urandom_range(0, 3));
            rst_n      = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1'b1; load_en = 1'b0; clr_flags = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
